// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter.
// Accepts scancode bytes into a small FIFO and sends each one as an 11-bit
// PS/2 frame: start bit, 8 data bits LSB first, odd parity, stop bit.
// Every frame is followed by an idle gap.
// Optional macro PS2_TX_AUTOBREAK_EN: each byte B is sent as B, F0, B.
module ps2_kbd_tx #(
  parameter int unsigned HALF_PERIOD = 600,
  parameter int unsigned GAP         = 6000,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk14,
  input  logic                          rst_n,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CMAX = (HALF_PERIOD > GAP) ? HALF_PERIOD : GAP;
  localparam int unsigned CW   = $clog2(CMAX);
  localparam logic [CW-1:0] HP_LOAD  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_GAP
  } state_t;

  // Frame layout, transmitted from bit 0 upward.
  function automatic logic [10:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [10:0]   shift_q, shift_d;
  logic          clk_q, clk_d;
  logic          data_q, data_d;
  logic          busy_q, busy_d;
`ifdef PS2_TX_AUTOBREAK_EN
  logic [1:0]    seq_q, seq_d;
  logic [7:0]    byte_q, byte_d;
`endif

  assign din_ready  = (count_q != (PW+1)'(FIFO_DEPTH));
  assign push       = din_valid & din_ready;
  assign fifo_count = count_q;
  assign ps2_clk    = clk_q;
  assign ps2_data   = data_q;
  assign busy       = busy_q;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk14) begin
    if (push) fifo_mem[wr_ptr_q] <= din;
  end

  // FIFO pointer and occupancy update; pointers wrap naturally (power of two).
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (pop && !push) count_d = count_q - (PW+1)'(1);
  end

  // Frame sequencer next-state; outputs are decoded from the current state
  // and registered, so they trail the state register by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef PS2_TX_AUTOBREAK_EN
    seq_d   = seq_q;
    byte_d  = byte_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = make_frame(fifo_mem[rd_ptr_q]);
          bit_d   = '0;
          cnt_d   = HP_LOAD;
          state_d = ST_BIT_HI;
`ifdef PS2_TX_AUTOBREAK_EN
          byte_d  = fifo_mem[rd_ptr_q];
          seq_d   = '0;
`endif
        end
      end
      ST_BIT_HI: begin
        if (cnt_q == '0) begin
          cnt_d   = HP_LOAD;
          state_d = ST_BIT_LO;
        end
      end
      ST_BIT_LO: begin
        if (cnt_q == '0) begin
          if (bit_q == 4'd10) begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            shift_d = {1'b1, shift_q[10:1]};
            bit_d   = bit_q + 4'd1;
            cnt_d   = HP_LOAD;
            state_d = ST_BIT_HI;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
`ifdef PS2_TX_AUTOBREAK_EN
          // Break sequence re-enters the bit states directly, skipping IDLE,
          // so the FIFO is not touched until all three frames are out.
          if (seq_q != 2'd2) begin
            seq_d   = seq_q + 2'd1;
            shift_d = make_frame((seq_q == 2'd0) ? 8'hF0 : byte_q);
            bit_d   = '0;
            cnt_d   = HP_LOAD;
            state_d = ST_BIT_HI;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    clk_d  = (state_q != ST_BIT_LO);
    data_d = (state_q == ST_BIT_HI || state_q == ST_BIT_LO) ? shift_q[0] : 1'b1;
    busy_d = (state_q != ST_IDLE) || (count_q != '0);
  end

  // State, FIFO bookkeeping and output registers; reset forces lines high at once.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      clk_q    <= 1'b1;
      data_q   <= 1'b1;
      busy_q   <= 1'b0;
`ifdef PS2_TX_AUTOBREAK_EN
      seq_q    <= '0;
      byte_q   <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      clk_q    <= clk_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
`ifdef PS2_TX_AUTOBREAK_EN
      seq_q    <= seq_d;
      byte_q   <= byte_d;
`endif
    end
  end

endmodule
